// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and rotating-priority search for the FIFO arbiters
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_CH = 32;

  // First set bit of req searching last+1, last+2, ... modulo ch_num; the nearest candidate wins.
  function automatic int unsigned rr_next(input logic [RR_MAX_CH-1:0] req,
                                          input int unsigned last,
                                          input int unsigned ch_num);
    int unsigned idx;
    int unsigned res;
    res = (last + 1) % ch_num;
    for (int unsigned i = RR_MAX_CH; i >= 1; i--) begin
      if (i <= ch_num) begin
        idx = (last + i) % ch_num;
        if (req[idx[4:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int CH_WIDTH = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0]   req,
  input  logic [CH_WIDTH-1:0] last,
  output logic [CH_WIDTH-1:0] idx,
  output logic                found
);

  always_comb begin
    found = |req;
    idx   = CH_WIDTH'(rr_next(RR_MAX_CH'(req), 32'(last), 32'(CH_NUM)));
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter draining show-ahead FIFOs into one stream
// FIFO_ARB_OUT_REG_EN adds a registered output stage (+1 cycle latency).
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_MAX   = 4,
  parameter int CH_WIDTH    = $clog2(CH_NUM),
  parameter int BURST_WIDTH = $clog2(BURST_MAX + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CH_NUM-1:0]            fifo_empty_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0] fifo_data_i,
  output logic [CH_NUM-1:0]            fifo_rd_o,
  output logic                         out_valid_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [CH_WIDTH-1:0]          out_ch_o,
  output logic                         out_last_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  arb_state_t             state, state_nxt;
  logic [CH_WIDTH-1:0]    grant, last_grant, pick_idx;
  logic                   pick_found;
  logic [BURST_WIDTH-1:0] burst_cnt;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic                   grant_avail, burst_end, pop, leave;

  rr_pick #(.CH_NUM(CH_NUM), .CH_WIDTH(CH_WIDTH)) u_pick (
    .req   (~fifo_empty_i),
    .last  (last_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign grant_avail = (state == GRANT) && !fifo_empty_i[grant];
  assign grant_data  = fifo_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign burst_end   = (burst_cnt == BURST_WIDTH'(BURST_MAX - 1));

`ifdef FIFO_ARB_OUT_REG_EN
  logic                  stage_valid, stage_last;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [CH_WIDTH-1:0]   stage_ch;

  // Pop whenever the stage is empty or being drained this cycle.
  assign pop = grant_avail && (!stage_valid || out_ready_i) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      stage_data  <= '0;
      stage_ch    <= '0;
    end else if (pop) begin
      stage_valid <= 1'b1;
      stage_last  <= burst_end;
      stage_data  <= grant_data;
      stage_ch    <= grant;
    end else if (out_ready_i) begin
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
    end
  end

  assign out_valid_o = stage_valid;
  assign out_data_o  = stage_data;
  assign out_ch_o    = stage_ch;
  assign out_last_o  = stage_last;
`else
  assign pop         = grant_avail && out_ready_i && !rst_i;
  assign out_valid_o = grant_avail;
  assign out_data_o  = grant_avail ? grant_data : '0;
  assign out_ch_o    = (state == GRANT) ? grant : '0;
  assign out_last_o  = grant_avail && burst_end;
`endif

  // A burst closes on its BURST_MAX-th pop or as soon as the granted FIFO runs dry.
  assign leave = (pop && burst_end) || ((state == GRANT) && fifo_empty_i[grant]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      burst_cnt  <= '0;
      last_grant <= CH_WIDTH'(CH_NUM - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant     <= pick_idx;
        burst_cnt <= '0;
      end
      if (pop) burst_cnt <= burst_cnt + 1'b1;
      if (leave) last_grant <= grant;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (leave) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o           = (state == GRANT);
    fifo_rd_o        = '0;
    fifo_rd_o[grant] = pop;
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - scoreboard bench for fifo_rr_arbiter (honours FIFO_ARB_OUT_REG_EN)
module tb_fifo_rr_arbiter;
  localparam int CH_NUM     = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_MAX  = 4;
  localparam int CH_WIDTH   = 2;

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic [CH_NUM-1:0]            fifo_empty_i;
  logic [CH_NUM*DATA_WIDTH-1:0] fifo_data_i;
  logic [CH_NUM-1:0]            fifo_rd_o;
  logic                         out_valid_o;
  logic [DATA_WIDTH-1:0]        out_data_o;
  logic [CH_WIDTH-1:0]          out_ch_o;
  logic                         out_last_o;
  logic                         out_ready_i;
  logic                         busy_o;

  fifo_rr_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(fifo_rd_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_last_o(out_last_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [CH_WIDTH-1:0]   ch;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } exp_t;

  exp_t                  sb[$];
  logic [DATA_WIDTH-1:0] fq[CH_NUM][$];
  int                    xfer_cyc[$];
  int                    checks = 0;
  int                    errors = 0;
  int                    cyc = 0;
  logic                  hold_pending = 1'b0;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [CH_WIDTH-1:0]   hold_ch;
  logic [CH_NUM-1:0]     rd_s;

  task automatic refresh();
    for (int k = 0; k < CH_NUM; k++) begin
      fifo_empty_i[k] = (fq[k].size() == 0);
      fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH] = (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  // One clock: sample at negedge, then apply the FIFO pops just after the rising edge.
  task automatic step();
    logic xfer;
    logic [CH_NUM-1:0] rd_exp;
    exp_t e;
    @(negedge clk_i);
    cyc++;
    rd_s = fifo_rd_o;
    xfer = out_valid_o && out_ready_i;
    if (!rst_i) begin
      checks++;
      if ((rd_s & fifo_empty_i) != '0 || (rd_s & (rd_s - 1'b1)) != '0) begin
        errors++;
        $display("FAIL rd_legal rd=%b empty=%b", rd_s, fifo_empty_i);
      end
`ifdef FIFO_ARB_OUT_REG_EN
      checks++;
      if (out_valid_o && !out_ready_i && rd_s != '0) begin
        errors++;
        $display("FAIL rd_while_stalled rd=%b exp 0", rd_s);
      end
`else
      rd_exp = xfer ? (CH_NUM'(1) << out_ch_o) : '0;
      checks++;
      if (rd_s !== rd_exp) begin
        errors++;
        $display("FAIL rd_on_accept rd=%b exp %b", rd_s, rd_exp);
      end
`endif
      if (hold_pending) begin
        checks++;
        if (!out_valid_o || out_data_o !== hold_data || out_ch_o !== hold_ch) begin
          errors++;
          $display("FAIL hold_stable got v=%b d=%h ch=%0d exp d=%h ch=%0d",
                   out_valid_o, out_data_o, out_ch_o, hold_data, hold_ch);
        end
      end
      hold_pending = out_valid_o && !out_ready_i;
      hold_data = out_data_o;
      hold_ch = out_ch_o;
      if (xfer) begin
        xfer_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got ch=%0d d=%h exp none", out_ch_o, out_data_o);
        end else begin
          e = sb.pop_front();
          if (out_ch_o !== e.ch || out_data_o !== e.data || out_last_o !== e.last) begin
            errors++;
            $display("FAIL word got ch=%0d d=%h last=%b exp ch=%0d d=%h last=%b",
                     out_ch_o, out_data_o, out_last_o, e.ch, e.data, e.last);
          end
        end
      end
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < CH_NUM; k++) if (rd_s[k] && fq[k].size() != 0) void'(fq[k].pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < CH_NUM; k++) fq[k].delete();
    sb.delete();
    xfer_cyc.delete();
    refresh();
    step();
    step();
    rst_i = 1'b0;
    hold_pending = 1'b0;
  endtask

  task automatic load(input int ch, input int n, input int base);
    for (int i = 0; i < n; i++) fq[ch].push_back(DATA_WIDTH'(base + i));
    refresh();
  endtask

  task automatic expect_word(input int ch, input int data, input logic last);
    exp_t e;
    e.ch = CH_WIDTH'(ch);
    e.data = DATA_WIDTH'(data);
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d exp 0", name, sb.size());
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || fifo_rd_o !== '0) begin
      errors++;
      $display("FAIL %s_idle got busy=%b v=%b rd=%b exp 0 0 0", name, busy_o, out_valid_o, fifo_rd_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid_o !== 0 || out_last_o !== 0 || out_data_o !== 0 || out_ch_o !== 0 ||
        busy_o !== 0 || fifo_rd_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h ch=%0d busy=%b rd=%b exp all 0",
               out_valid_o, out_last_o, out_data_o, out_ch_o, busy_o, fifo_rd_o);
    end
  endtask

  task automatic test_all_empty();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle("all_empty");
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    load(0, 10, 8'h10);
    for (int i = 0; i < 10; i++) expect_word(0, 8'h10 + i, (i == 3) || (i == 7));
    drain("single", 60);
    checks++;
    if (xfer_cyc.size() < 10 || xfer_cyc[1] - xfer_cyc[0] != 1 || xfer_cyc[4] - xfer_cyc[3] != 2) begin
      errors++;
      $display("FAIL single_timing got n=%0d gaps=%0d,%0d exp 10 1,2", xfer_cyc.size(),
               (xfer_cyc.size() >= 2) ? xfer_cyc[1] - xfer_cyc[0] : -1,
               (xfer_cyc.size() >= 5) ? xfer_cyc[4] - xfer_cyc[3] : -1);
    end
    repeat (4) step();
    check_idle("single_end");
  endtask

  task automatic test_four_channels();
    do_reset();
    for (int k = 0; k < CH_NUM; k++) load(k, 8, k * 32);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < CH_NUM; k++)
        for (int i = 0; i < BURST_MAX; i++)
          expect_word(k, k * 32 + r * BURST_MAX + i, i == BURST_MAX - 1);
    drain("four_ch", 200);
    checks++;
    if (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 0) begin
      errors++;
      $display("FAIL four_ch_left got %0d exp 0",
               fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size());
    end
    repeat (4) step();
    check_idle("four_ch_end");
  endtask

  task automatic test_ready_toggle();
    int n = 0;
    do_reset();
    load(2, 2, 8'hA0);
    expect_word(2, 8'hA0, 1'b0);
    expect_word(2, 8'hA1, 1'b0);
    while (sb.size() != 0 && n < 40) begin
      out_ready_i = ~out_ready_i;
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_drain pending=%0d exp 0", sb.size());
    end
    out_ready_i = 1'b1;
    repeat (4) step();
    check_idle("toggle_end");
  endtask

  task automatic test_reset_mid_burst();
    int left;
    do_reset();
    load(2, 6, 8'h40);
    expect_word(2, 8'h40, 1'b0);
    expect_word(2, 8'h41, 1'b0);
    drain("mid_pre", 20);
    rst_i = 1'b1;
    step();
    checks++;
    if (out_valid_o !== 0 || out_last_o !== 0 || out_data_o !== 0 || out_ch_o !== 0 ||
        busy_o !== 0 || fifo_rd_o !== 0) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%b l=%b d=%h ch=%0d busy=%b rd=%b exp all 0",
               out_valid_o, out_last_o, out_data_o, out_ch_o, busy_o, fifo_rd_o);
    end
`ifdef FIFO_ARB_OUT_REG_EN
    left = 3;
`else
    left = 4;
`endif
    checks++;
    if (fq[2].size() != left) begin
      errors++;
      $display("FAIL mid_reset_fifo got %0d exp %0d", fq[2].size(), left);
    end
    rst_i = 1'b0;
    hold_pending = 1'b0;
    load(0, 2, 8'h80);
    expect_word(0, 8'h80, 1'b0);
    expect_word(0, 8'h81, 1'b0);
    for (int i = 0; i < fq[2].size(); i++) expect_word(2, fq[2][i], i == BURST_MAX - 1);
    drain("mid_post", 40);
  endtask

  initial begin
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    fifo_empty_i = '1;
    fifo_data_i = '0;
    test_reset();
    test_all_empty();
    test_single_channel();
    test_four_channels();
    test_ready_toggle();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
